// File: rtl/lvt_pkg.sv
// ----------------------------------------------------------------------------
// lvt_pkg
//   Shared constants and helper functions for the LVT replica count array.
//   - HIT_W      : width of per-port hit counts / collision offsets (0..8).
//   - CNT_EXT    : headroom bits added to the counter width for modulo sums.
//   - MOD_STEPS  : number of conditional subtract stages used by mod_r.
//   - clog2      : ceiling log2, used for elaboration-time width checks.
//   - depth_of   : entry count for a given address width.
//   - mod_r      : modulo R by repeated conditional subtraction (no '%').
// ----------------------------------------------------------------------------
package lvt_pkg;

    localparam int HIT_W     = 4;
    localparam int CNT_EXT   = 4;
    // Sums never exceed (R-1) + 8, so with R >= 2 at most 4 subtractions
    // are needed; 8 stages leave margin.
    localparam int MOD_STEPS = 8;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

    function automatic int depth_of(input int index_width);
        return 1 << index_width;
    endfunction

    function automatic int mod_r(input int value, input int r);
        int v;
        v = value;
        for (int i = 0; i < MOD_STEPS; i++) begin
            if (v >= r) begin
                v = v - r;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/lvt_replica_count_array_if.sv
// ----------------------------------------------------------------------------
// lvt_replica_count_array_if
//   Request/response bundle of the replica count array.
//   master : drives w_en/w_addr, inv_en/inv_addr, rd_en/rd_addr; receives
//            w_index, w_index_vld, w_was_valid, w_overflow, rd_vld,
//            rd_valid, rd_count.
//   slave  : the array itself (opposite directions).
//   Port p of the write bus sits at w_addr[p*INDEX_WIDTH +: INDEX_WIDTH] and
//   w_index[p*N_BITS_R +: N_BITS_R].
// ----------------------------------------------------------------------------
interface lvt_replica_count_array_if #(
    parameter int INDEX_WIDTH = 8,
    parameter int N_BITS_R    = 2,
    parameter int W_PORTS     = 2
);
    logic [W_PORTS-1:0]             w_en;
    logic [W_PORTS*INDEX_WIDTH-1:0] w_addr;
    logic                           inv_en;
    logic [INDEX_WIDTH-1:0]         inv_addr;
    logic                           rd_en;
    logic [INDEX_WIDTH-1:0]         rd_addr;
    logic [W_PORTS*N_BITS_R-1:0]    w_index;
    logic [W_PORTS-1:0]             w_index_vld;
    logic [W_PORTS-1:0]             w_was_valid;
    logic                           w_overflow;
    logic                           rd_vld;
    logic                           rd_valid;
    logic [N_BITS_R-1:0]            rd_count;

    modport master (
        output w_en, w_addr, inv_en, inv_addr, rd_en, rd_addr,
        input  w_index, w_index_vld, w_was_valid, w_overflow,
               rd_vld, rd_valid, rd_count
    );

    modport slave (
        input  w_en, w_addr, inv_en, inv_addr, rd_en, rd_addr,
        output w_index, w_index_vld, w_was_valid, w_overflow,
               rd_vld, rd_valid, rd_count
    );
endinterface

// File: rtl/lvt_collision_offset.sv
// ----------------------------------------------------------------------------
// lvt_collision_offset
//   Combinational intra-cycle collision analysis across the write ports.
//   i_en       : per-port write request.
//   i_addr     : per-port address, port p at [p*INDEX_WIDTH +: INDEX_WIDTH].
//   o_off      : per-port count of lower-numbered active ports on the same
//                address (HIT_W bits per port).
//   o_hits     : per-port count of all active ports on its own address,
//                itself included (HIT_W bits per port).
//   o_overflow : some address is hit by more than R ports this cycle.
// ----------------------------------------------------------------------------
module lvt_collision_offset
    import lvt_pkg::*;
#(
    parameter int INDEX_WIDTH = 8,
    parameter int R           = 4,
    parameter int W_PORTS     = 2
) (
    input  logic [W_PORTS-1:0]             i_en,
    input  logic [W_PORTS*INDEX_WIDTH-1:0] i_addr,
    output logic [W_PORTS*HIT_W-1:0]       o_off,
    output logic [W_PORTS*HIT_W-1:0]       o_hits,
    output logic                           o_overflow
);

    logic [HIT_W-1:0] w_off  [W_PORTS];
    logic [HIT_W-1:0] w_hits [W_PORTS];

    // NOTE: every variable assigned in always_comb gets a default first so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        o_off      = '0;
        o_hits     = '0;
        o_overflow = 1'b0;
        for (int p = 0; p < W_PORTS; p++) begin
            w_off[p]  = '0;
            w_hits[p] = '0;
            for (int q = 0; q < W_PORTS; q++) begin
                if (i_en[p] && i_en[q] &&
                    (i_addr[p*INDEX_WIDTH +: INDEX_WIDTH] ==
                     i_addr[q*INDEX_WIDTH +: INDEX_WIDTH])) begin
                    w_hits[p] = w_hits[p] + HIT_W'(1);
                    if (q < p) begin
                        w_off[p] = w_off[p] + HIT_W'(1);
                    end
                end
            end
            if (i_en[p] && (int'(w_hits[p]) > R)) begin
                o_overflow = 1'b1;
            end
            o_off[p*HIT_W +: HIT_W]  = w_off[p];
            o_hits[p*HIT_W +: HIT_W] = w_hits[p];
        end
    end

endmodule

// File: rtl/lvt_replica_count_array.sv
// ----------------------------------------------------------------------------
// lvt_replica_count_array
//   Per-address valid bit + modulo-R replica round-robin counter, shared by
//   W_PORTS write ports. Each active port receives a registered replica index;
//   ports colliding on one address get consecutive indices in port order.
//   An invalidate request clears its entry before the same cycle's writes.
//   clk   : rising-edge clock.
//   reset : synchronous, active-high; clears all entries and outputs.
//   bus   : lvt_replica_count_array_if.slave (requests in, grants/lookup out).
//   Optional macro LVT_RD_BYPASS_EN: lookup returns post-update state
//   (same-cycle invalidate and writes included); otherwise pre-update state.
// ----------------------------------------------------------------------------
module lvt_replica_count_array
    import lvt_pkg::*;
#(
    parameter int INDEX_WIDTH = 8,
    parameter int R           = 4,
    parameter int N_BITS_R    = 2,
    parameter int W_PORTS     = 2
) (
    input logic                     clk,
    input logic                     reset,
    lvt_replica_count_array_if.slave bus
);

    localparam int DEPTH = depth_of(INDEX_WIDTH);
    localparam int SUM_W = N_BITS_R + CNT_EXT;

    if ((2 ** N_BITS_R) < R || clog2(R) > N_BITS_R) begin : g_bad_nbits
        $error("N_BITS_R too small for R");
    end
    if (R < 2) begin : g_bad_r
        $error("R must be at least 2");
    end
    if (W_PORTS < 1 || W_PORTS > 8) begin : g_bad_ports
        $error("W_PORTS must be within 1..8");
    end

    logic                        r_valid [DEPTH];
    logic [N_BITS_R-1:0]         r_cnt   [DEPTH];

    logic [W_PORTS*N_BITS_R-1:0] r_w_index;
    logic [W_PORTS-1:0]          r_w_index_vld;
    logic [W_PORTS-1:0]          r_w_was_valid;
    logic                        r_w_overflow;
    logic                        r_rd_vld;
    logic                        r_rd_valid;
    logic [N_BITS_R-1:0]         r_rd_count;

    logic [W_PORTS*HIT_W-1:0]    w_off;
    logic [W_PORTS*HIT_W-1:0]    w_hits;
    logic                        w_overflow;

    logic [INDEX_WIDTH-1:0]      w_port_addr [W_PORTS];
    logic [N_BITS_R-1:0]         w_cnt_eff   [W_PORTS];
    logic [N_BITS_R-1:0]         w_grant     [W_PORTS];
    logic [N_BITS_R-1:0]         w_next_cnt  [W_PORTS];
    logic [W_PORTS-1:0]          w_valid_eff;
    logic                        w_rd_valid_nxt;
    logic [N_BITS_R-1:0]         w_rd_count_nxt;

    lvt_collision_offset #(
        .INDEX_WIDTH (INDEX_WIDTH),
        .R           (R),
        .W_PORTS     (W_PORTS)
    ) u_collision (
        .i_en       (bus.w_en),
        .i_addr     (bus.w_addr),
        .o_off      (w_off),
        .o_hits     (w_hits),
        .o_overflow (w_overflow)
    );

    // Per-port view of the entry after a same-cycle invalidate, plus the
    // granted index (offset by earlier colliding ports) and the entry's
    // next counter (advanced by every port hitting that address).
    always_comb begin
        w_valid_eff = '0;
        for (int p = 0; p < W_PORTS; p++) begin
            w_port_addr[p] = bus.w_addr[p*INDEX_WIDTH +: INDEX_WIDTH];
            if (bus.inv_en && (bus.inv_addr == w_port_addr[p])) begin
                w_cnt_eff[p]   = '0;
                w_valid_eff[p] = 1'b0;
            end else begin
                w_cnt_eff[p]   = r_cnt[w_port_addr[p]];
                w_valid_eff[p] = r_valid[w_port_addr[p]];
            end
            w_grant[p]    = N_BITS_R'(mod_r(int'(SUM_W'(w_cnt_eff[p]) +
                                           SUM_W'(w_off[p*HIT_W +: HIT_W])), R));
            w_next_cnt[p] = N_BITS_R'(mod_r(int'(SUM_W'(w_cnt_eff[p]) +
                                           SUM_W'(w_hits[p*HIT_W +: HIT_W])), R));
        end
    end

`ifdef LVT_RD_BYPASS_EN
    // Post-update view: invalidate first, then any write to the same address.
    always_comb begin
        w_rd_valid_nxt = r_valid[bus.rd_addr];
        w_rd_count_nxt = r_cnt[bus.rd_addr];
        if (bus.inv_en && (bus.inv_addr == bus.rd_addr)) begin
            w_rd_valid_nxt = 1'b0;
            w_rd_count_nxt = '0;
        end
        for (int p = 0; p < W_PORTS; p++) begin
            if (bus.w_en[p] && (w_port_addr[p] == bus.rd_addr)) begin
                w_rd_valid_nxt = 1'b1;
                w_rd_count_nxt = w_next_cnt[p];
            end
        end
    end
`else
    always_comb begin
        w_rd_valid_nxt = r_valid[bus.rd_addr];
        w_rd_count_nxt = r_cnt[bus.rd_addr];
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the entry array is reset explicitly because a cleared
            // table (valid=0, cnt=0) is architectural state, not a cache.
            for (int a = 0; a < DEPTH; a++) begin
                r_valid[a] <= 1'b0;
                r_cnt[a]   <= '0;
            end
            r_w_index     <= '0;
            r_w_index_vld <= '0;
            r_w_was_valid <= '0;
            r_w_overflow  <= 1'b0;
            r_rd_vld      <= 1'b0;
            r_rd_valid    <= 1'b0;
            r_rd_count    <= '0;
        end else begin
            if (bus.inv_en) begin
                r_valid[bus.inv_addr] <= 1'b0;
                r_cnt[bus.inv_addr]   <= '0;
            end
            // Later assignments win, so writes override the invalidate; all
            // ports hitting one address carry the same next counter value.
            for (int p = 0; p < W_PORTS; p++) begin
                if (bus.w_en[p]) begin
                    r_valid[w_port_addr[p]]            <= 1'b1;
                    r_cnt[w_port_addr[p]]              <= w_next_cnt[p];
                    r_w_index[p*N_BITS_R +: N_BITS_R] <= w_grant[p];
                end
            end
            r_w_index_vld <= bus.w_en;
            r_w_was_valid <= bus.w_en & w_valid_eff;
            r_w_overflow  <= w_overflow;
            r_rd_vld      <= bus.rd_en;
            if (bus.rd_en) begin
                r_rd_valid <= w_rd_valid_nxt;
                r_rd_count <= w_rd_count_nxt;
            end
        end
    end

    assign bus.w_index     = r_w_index;
    assign bus.w_index_vld = r_w_index_vld;
    assign bus.w_was_valid = r_w_was_valid;
    assign bus.w_overflow  = r_w_overflow;
    assign bus.rd_vld      = r_rd_vld;
    assign bus.rd_valid    = r_rd_valid;
    assign bus.rd_count    = r_rd_count;

endmodule

// File: doc/lvt_replica_count_array.md
Name: lvt_replica_count_array

Overview:
- Multi-write-port successor to the single-port valid/replica-count array used by the LVT memory.
- Keeps one entry per address: a valid bit and a replica round-robin counter.
- Each write port gets a registered BRAM replica index in `0..R-1`, with intra-cycle address collisions resolved in port order.
- Adds an invalidate port, a registered lookup port and a collision overflow flag; sits beside the LVT, feeding replica selects to the BRAM bank write muxes.

Parameters:
- `INDEX_WIDTH`, 8: address width; depth = `2**INDEX_WIDTH` entries.
- `R`, 4: replica count; counters are modulo `R`, and `R` need not be a power of two (`R >= 2`).
- `N_BITS_R`, 2: counter/index width; must satisfy `2**N_BITS_R >= R`; elaboration error otherwise.
- `W_PORTS`, 2: number of write ports (1..8).

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `w_en`  in  `W_PORTS`  per-port write request.
- `w_addr`  in  `W_PORTS*INDEX_WIDTH`  per-port address; port p is at `[p*INDEX_WIDTH +: INDEX_WIDTH]`.
- `inv_en`  in  1  invalidate request.
- `inv_addr`  in  `INDEX_WIDTH`  invalidate address.
- `rd_en`  in  1  lookup request.
- `rd_addr`  in  `INDEX_WIDTH`  lookup address.
- `w_index`  out  `W_PORTS*N_BITS_R`  registered granted replica index per port.
- `w_index_vld`  out  `W_PORTS`  registered strobe; `w_index` is valid for port p.
- `w_was_valid`  out  `W_PORTS`  entry valid bit as seen before this write.
- `w_overflow`  out  1  more than `R` ports hit one address in the cycle.
- `rd_vld`  out  1  registered lookup strobe.
- `rd_valid`  out  1  looked-up valid bit.
- `rd_count`  out  `N_BITS_R`  looked-up counter.

Behaviour:
- **Reset.** `reset` high at an edge clears every entry (valid=0, count=0) and all outputs to 0 in that edge. Reset overrides any concurrent request. Requests in the reset cycle are dropped; no grant is produced for them.
- **Per-entry state.** `valid[a]`, `cnt[a]`, always with `cnt < R`.
- **Invalidate first.** If `inv_en`, entry `inv_addr` is treated as valid=0, cnt=0 before write evaluation in the same cycle.
- **Grant offset.** For port p with `w_en[p]`: `off_p` = number of ports q<p with `w_en[q]` and `w_addr[q]==w_addr[p]`.
- **Grant value.** `grant_p = (cnt_eff[w_addr[p]] + off_p) mod R`, where `cnt_eff` is post-invalidate.
- **Entry update.** Per address hit by k ports: `cnt <= (cnt_eff + k) mod R`, `valid <= 1`.
- **Modulo arithmetic.** Computed at width `N_BITS_R+4` then reduced by repeated conditional subtract of `R`. No `%` operator.
- **Latency.** Grants are registered: `w_index`/`w_index_vld`/`w_was_valid` appear one cycle after `w_en`. `w_index_vld[p]` is 0 where `w_en[p]` was 0, and `w_index[p]` then holds its previous value.
- **Overflow.** `w_overflow` is a one-cycle registered pulse when any address sees k>R in a cycle. Grants still wrap modulo `R`; there is no stall.
- **Lookup.** `rd_en` gives `rd_vld=1` next cycle with `rd_valid`/`rd_count` of `rd_addr`. Default: pre-update state of the request cycle, ignoring that cycle's invalidate and writes. `rd_valid`/`rd_count` hold when `rd_en=0`.
- **Wrap.** `cnt=R-1` plus one hit gives 0.
- **No handshake back-pressure.** Every request is accepted every cycle.

Optional Feature:
- Macro: `LVT_RD_BYPASS_EN`.
- Defined: the lookup returns post-update state, i.e. it includes same-cycle invalidate and writes to `rd_addr`. Example: `cnt=1`, one write and a lookup to the same address give `rd_count=2`.
- Undefined: pre-update state as above (same example gives `rd_count=1`).
- Latency is 1 cycle either way.

Decomposition:
- Package `lvt_pkg`:
  - function `mod_r(value, R)`;
  - function `clog2`;
  - localparam `DEPTH = 2**INDEX_WIDTH` helper.
- Sub-module `lvt_collision_offset`: combinational. Per-port `off_p`, per-port hit-count k for its own address, and the overflow detect across `W_PORTS`.
- Top: entry storage, invalidate/write update, output registers, lookup path.

Test Plan:
1. **Reset clear.** Reset 1 cycle, then `rd_en` at addr 0x10 → `rd_vld=1`, `rd_valid=0`, `rd_count=0`. All grant outputs are 0 during and after reset.
2. **Sequential wrap.** Port0 writes addr 0x05 for 5 consecutive cycles (`R=4`) → `w_index` 0,1,2,3,0. `w_was_valid` is 0 then 1,1,1,1.
3. **Same-cycle collision.** Both ports write addr 0x07 with `cnt=3` → port0 gets 3, port1 gets 0, `cnt` becomes 1. Different addresses instead → each port gets its own entry's `cnt`.
4. **Invalidate and write together.** `inv_addr`=0x07 and port0 writes 0x07 with `cnt=2` → grant 0, `cnt=1`, valid=1.
5. **Overflow.** `W_PORTS=8`, `R=4`, with all 8 ports on addr 0 → grants 0,1,2,3,0,1,2,3, `w_overflow` pulse 1 cycle, `cnt` 0.
6. **Reset mid-stream and lookup timing.** Reset asserted while writes are active → no `w_index_vld` next cycle, entries cleared. Lookup with same-cycle write at `cnt=1` → `rd_count=1`, or 2 with `LVT_RD_BYPASS_EN`.
